arb_tx_mux: RTL and testbench
=============================

Name: arb_tx_mux

Overview:
Four-channel byte collector and transmit multiplexer that feeds `priority_arbiter` and consumes its grant. Each channel deposits one byte into a holding register. The holding-register valid bits drive the arbiter's `req` lines. The registered one-hot `grant` chooses which byte is handed to the shared UART transmitter through a start/busy/done handshake, and a timeout guards against a stalled transmitter.

Parameters:
- DATA_W, 8, width of each channel byte and of tx_data
- TIMEOUT_CYC, 1024, maximum cycles spent in WAIT_DONE before the byte is dropped (minimum legal value 2)
- CNT_W, 11, width of the timeout counter (must satisfy 2**CNT_W > TIMEOUT_CYC)

Ports:
- clk  in  1  single system clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- ch_valid  in  4  per-channel byte offer
- ch_data  in  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- ch_ready  out  4  per-channel acceptance; equals ~hold_vld
- req  out  4  to the arbiter; equals hold_vld (combinational from flops)
- grant  in  4  registered one-hot grant from the arbiter
- tx_start  out  1  one-cycle start strobe to the UART TX
- tx_data  out  DATA_W  byte for the UART TX, stable from START until leaving WAIT_DONE
- tx_busy  in  1  UART TX busy; start is only issued while this is low
- tx_done  in  1  one-cycle pulse when the UART TX finishes a byte
- tx_sent  out  4  one-hot, one-cycle pulse naming the channel whose byte completed
- timeout_err  out  1  one-cycle pulse when a byte is dropped on timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; hold_vld=0000; sel=0; timeout counter=0; tx_start=0; tx_data=0; tx_sent=0000; timeout_err=0; busy=0. Reset overrides every other action, including a reset in the middle of a transfer. Any pending bytes are discarded.
- Holding register i loads ch_data[i] and sets hold_vld[i] when ch_valid[i]&&ch_ready[i]. It clears only when its byte completes or times out.
- A channel that is cleared in cycle N shows ch_ready high in cycle N+1. Load and clear can never coincide on the same channel.
- FSM, state enumeration IDLE, ARB, START, WAIT_DONE:
  - IDLE: if hold_vld!=0, go to ARB. The arbiter registers grant from req on this same edge.
  - ARB: sample grant.
    - If grant is one-hot and (grant & hold_vld)!=0, then sel<=index(grant), tx_data<=hold_data[sel], go to START.
    - Otherwise (zero, multi-hot, or naming an empty channel), return to IDLE with no side effects and retry.
  - START: tx_start = (state==START && !tx_busy), combinational.
    - If tx_busy=0, go to WAIT_DONE and clear the counter.
    - If tx_busy=1, hold in START with no start strobe.
  - WAIT_DONE: the counter increments each cycle.
    - If tx_done=1: clear hold_vld[sel], pulse tx_sent[sel], go to IDLE.
    - Else if counter==TIMEOUT_CYC-1: clear hold_vld[sel], pulse timeout_err, go to IDLE.
    - If tx_done and timeout land in the same cycle, tx_done wins and timeout_err stays 0.
- Grant is ignored outside ARB. Arbitration is re-run after every byte, so priority order is ch3>ch2>ch1>ch0 at each ARB sample.
- Best-case latency: byte loaded at edge 0 → ARB after edge 1 → START after edge 2 → tx_start high in the cycle after edge 2 → tx_sent pulses in the cycle after the edge on which tx_done is seen.
- tx_done outside WAIT_DONE is ignored.

Decomposition:
- Package arb_tx_pkg holds:
  - the state enum (IDLE, ARB, START, WAIT_DONE)
  - the N_CH=4 constant
  - a function onehot_to_idx
  - a function is_onehot
- One sub-module, arb_chan_hold: a single-channel holding register with valid/ready, load and clear, parameterised by DATA_W. It is instantiated four times.

Test Plan:
- Single byte, ch2 loads 0x5A, tx_busy=0, tx_done 10 cycles after start → req=0100; tx_start pulses once with tx_data=0x5A two cycles after load; tx_sent=0100; ch_ready[2] is high again the cycle after tx_sent.
- Simultaneous load, ch0=0x11 and ch3=0x33 → first transfer is 0x33 with tx_sent=1000, then 0x11 with tx_sent=0001; exactly two tx_start pulses.
- tx_busy held high for 5 cycles on entering START → no tx_start while busy; exactly one tx_start on the first cycle tx_busy=0.
- TIMEOUT_CYC=8, ch1 loads 0xA5, tx_done never arrives → timeout_err pulses on the 8th WAIT_DONE cycle; tx_sent stays 0000; hold_vld[1] clears; FSM returns to IDLE.
- rst asserted in WAIT_DONE with ch0 and ch2 holding bytes → next cycle all outputs are at reset values, req=0000 and ch_ready=1111; a later tx_done produces no tx_sent.
- Bench forces grant=0000, then 0110, in ARB with ch1 pending → FSM returns to IDLE with no tx_start; with a correct grant=0010 the byte is sent normally.

Source files
------------

// File: rtl/arb_tx_pkg.sv
// Shared types and helpers for the four-channel arbitrated transmit mux.
package arb_tx_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    START,
    WAIT_DONE
  } state_t;

  function automatic logic is_onehot(input logic [N_CH-1:0] v);
    return (v != '0) && ((v & (v - N_CH'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_chan_hold.sv
// Single-channel byte holding register: accepts one byte, holds it until cleared.
module arb_chan_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              ready,
  output logic              vld,
  output logic [DATA_W-1:0] q
);

  assign ready = ~vld;

  // A full register never loads, so clear and load cannot collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (valid && ready) begin
      vld <= 1'b1;
      q   <= data;
    end
  end

endmodule

// File: rtl/arb_tx_mux.sv
// Collects one byte per channel, requests arbitration and drives the shared
// UART transmitter with a start/busy/done handshake and a stall timeout.
module arb_tx_mux
  import arb_tx_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_ready,
  output logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          grant,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [N_CH-1:0]          tx_sent,
  output logic                     timeout_err,
  output logic                     busy
);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     sel, sel_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0]    tx_data_nxt;
  logic [N_CH-1:0]      tx_sent_nxt;
  logic                 timeout_err_nxt;
  logic [N_CH-1:0]      hold_vld;
  logic [N_CH-1:0]      clr;
  logic [DATA_W-1:0]    hold_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_hold
    arb_chan_hold #(.DATA_W(DATA_W)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .valid (ch_valid[i]),
      .data  (ch_data[i*DATA_W +: DATA_W]),
      .clr   (clr[i]),
      .ready (ch_ready[i]),
      .vld   (hold_vld[i]),
      .q     (hold_data[i])
    );
  end

  assign req      = hold_vld;
  assign busy     = (state != IDLE);
  assign tx_start = (state == START) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      tx_data     <= '0;
      tx_sent     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      tx_data     <= tx_data_nxt;
      tx_sent     <= tx_sent_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Grant is only trusted in ARB; anything but a one-hot hit on a full channel retries.
  always_comb begin
    state_nxt       = state;
    sel_nxt         = sel;
    cnt_nxt         = cnt;
    tx_data_nxt     = tx_data;
    tx_sent_nxt     = '0;
    timeout_err_nxt = 1'b0;
    clr             = '0;
    case (state)
      IDLE: begin
        if (hold_vld != '0) state_nxt = ARB;
      end
      ARB: begin
        if (is_onehot(grant) && ((grant & hold_vld) != '0)) begin
          sel_nxt     = onehot_to_idx(grant);
          tx_data_nxt = hold_data[onehot_to_idx(grant)];
          state_nxt   = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (!tx_busy) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (tx_done) begin
          clr[sel]         = 1'b1;
          tx_sent_nxt[sel] = 1'b1;
          state_nxt        = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          clr[sel]        = 1'b1;
          timeout_err_nxt = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arb_tx_mux.sv
// Directed and randomized checks of arb_tx_mux against a transaction-level model
// and a behavioural priority arbiter (ch3 highest, grant registered from req).
module tb_arb_tx_mux;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  ch_valid;
  logic [31:0] ch_data;
  logic [3:0]  ch_ready;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [3:0]  tx_sent;
  logic        timeout_err;
  logic        busy;

  logic [3:0]  arb_q;
  logic        force_en;
  logic [3:0]  force_val;

  int nerr = 0;
  int nchk = 0;

  arb_tx_mux #(.DATA_W(8), .TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .req         (req),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_sent     (tx_sent),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pri4(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 4'(1 << i);
    end
    return r;
  endfunction

  // Behavioural arbiter: registered one-hot grant of the highest requesting channel.
  always @(posedge clk) begin
    if (rst) arb_q <= '0;
    else     arb_q <= pri4(req);
  end
  assign grant = force_en ? force_val : arb_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, return at the falling edge for sampling.
  task automatic cyc(input logic b, input logic d);
    @(posedge clk);
    #1;
    ch_valid = '0;
    tx_busy  = b;
    tx_done  = d;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] m, input logic [31:0] d);
    @(posedge clk);
    #1;
    ch_valid = m;
    ch_data  = d;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    @(negedge clk);
  endtask

  // Called at an IDLE cycle with bytes pending; ch is the channel the priority rule must pick.
  // k is the WAIT_DONE cycle (1-based) carrying tx_done; k > TO means it never arrives in time.
  task automatic xfer(input int ch, input logic [7:0] d, input int nbusy, input int k,
                      input string tag);
    int last;
    cyc(nbusy > 0, 1'b0);
    chk({tag, "_arb_start"}, 32'(tx_start), 32'd0);
    for (int b = 0; b < nbusy; b++) begin
      cyc(1'b1, 1'b0);
      chk({tag, "_busy_nostart"}, 32'(tx_start), 32'd0);
    end
    cyc(1'b0, 1'b0);
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    last = (k <= int'(TO)) ? k : int'(TO);
    for (int i = 1; i <= last; i++) begin
      cyc(1'b0, i == k);
      chk({tag, "_wait_nostart"}, 32'(tx_start), 32'd0);
      if (i < last) chk({tag, "_wait_nosent"}, 32'(tx_sent), 32'd0);
    end
    cyc(1'b0, 1'b0);
    chk({tag, "_sent"}, 32'(tx_sent), (k <= int'(TO)) ? 32'(1 << ch) : 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_err), (k <= int'(TO)) ? 32'd0 : 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(ch_ready[ch]), 32'd1);
  endtask

  initial begin
    logic [3:0]  m;
    logic [31:0] d;
    logic [7:0]  b;

    rst = 1'b1; ch_valid = '0; ch_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    force_en = 1'b0; force_val = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_ready", 32'(ch_ready), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'h0);
    chk("rst_sent", 32'(tx_sent), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Single byte on ch2, done on the 10th WAIT_DONE cycle
    load(4'b0100, 32'h005A_0000);
    cyc(1'b0, 1'b0);
    chk("single_req", 32'(req), 32'h4);
    chk("single_ready", 32'(ch_ready), 32'hB);
    xfer(2, 8'h5A, 0, 10, "single");
    cyc(1'b0, 1'b0);
    chk("single_ready_after", 32'(ch_ready), 32'hF);

    // ch0 and ch3 together: ch3 first
    load(4'b1001, 32'h3300_0011);
    cyc(1'b0, 1'b0);
    chk("dual_req", 32'(req), 32'h9);
    xfer(3, 8'h33, 0, 3, "dual_a");
    xfer(0, 8'h11, 0, 4, "dual_b");

    // Transmitter busy for 5 cycles in START
    load(4'b0010, 32'h0000_C300);
    cyc(1'b0, 1'b0);
    xfer(1, 8'hC3, 5, 2, "busy");

    // Stalled transmitter, then done on the very last allowed cycle
    load(4'b0010, 32'h0000_A500);
    cyc(1'b0, 1'b0);
    xfer(1, 8'hA5, 0, TO + 4, "tmo");
    chk("tmo_req", 32'(req), 32'h0);
    load(4'b1000, 32'h7E00_0000);
    cyc(1'b0, 1'b0);
    xfer(3, 8'h7E, 0, TO, "edge_done");

    // Reset in the middle of a transfer
    load(4'b0101, 32'h0022_0044);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("mid_start", 32'(tx_start), 32'd1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(req), 32'h0);
    chk("mid_rst_ready", 32'(ch_ready), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_txdata", 32'(tx_data), 32'h0);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("mid_rst_nosent", 32'(tx_sent), 32'h0);
    chk("mid_rst_notmo", 32'(timeout_err), 32'd0);

    // Bad grants in ARB: zero, multi-hot, empty channel
    load(4'b0010, 32'h0000_6900);
    cyc(1'b0, 1'b0);
    force_en = 1'b1; force_val = 4'b0000;
    cyc(1'b0, 1'b0);
    chk("bad0_arb", 32'(busy), 32'd1);
    cyc(1'b0, 1'b0);
    chk("bad0_idle", 32'(busy), 32'd0);
    chk("bad0_nostart", 32'(tx_start), 32'd0);
    force_val = 4'b0110;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("bad2_idle", 32'(busy), 32'd0);
    chk("bad2_nostart", 32'(tx_start), 32'd0);
    force_val = 4'b0100;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("bad_empty_idle", 32'(busy), 32'd0);
    chk("bad_req_kept", 32'(req), 32'h2);
    force_en = 1'b0;
    xfer(1, 8'h69, 0, 2, "good_grant");

    // Random batches: model drains them highest channel first, each sent or timed out
    for (int r = 0; r < 20; r++) begin
      m = 4'($urandom_range(1, 15));
      d = $urandom;
      load(m, d);
      cyc(1'b0, 1'b0);
      chk("rnd_req", 32'(req), 32'(m));
      for (int c = 3; c >= 0; c--) begin
        if (m[c]) begin
          b = d[c*8 +: 8];
          xfer(c, b, $urandom_range(0, 3), $urandom_range(1, TO + 3), "rnd");
        end
      end
      chk("rnd_drained", 32'(req), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
